// File: rtl/bp_gshare_btb_pkg.sv
// Shared constants for the gshare/bimodal branch predictor: index modes, BTB entry types,
// and the weakly-not-taken counter reset value.
package bp_gshare_btb_pkg;
    localparam int   BP_MODE_BIMODAL = 0;
    localparam int   BP_MODE_GSHARE  = 1;
    localparam logic BP_TYPE_BR      = 1'b0;
    localparam logic BP_TYPE_J       = 1'b1;

    function automatic int cnt_init(input int cnt_bits);
        return (1 << (cnt_bits - 1)) - 1;
    endfunction
endpackage

// File: rtl/bp_gshare_btb_pht.sv
// Pattern history table: one combinational read port and one saturating-update write port.
// Reads are zero latency; a write lands on the next edge. There is no backpressure.
module bp_pht
    import bp_gshare_btb_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int CNT_BITS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(ENTRIES)-1:0]  rd_idx_i,
    output logic [CNT_BITS-1:0]         rd_cnt_o,
    input  logic                        wr_en_i,
    input  logic [$clog2(ENTRIES)-1:0]  wr_idx_i,
    input  logic                        wr_taken_i
);
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(cnt_init(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    logic [CNT_BITS-1:0] cnt_q [ENTRIES];
    logic [CNT_BITS-1:0] wr_cur;
    logic [CNT_BITS-1:0] wr_d;

    assign rd_cnt_o = cnt_q[rd_idx_i];
    assign wr_cur   = cnt_q[wr_idx_i];

    always_comb begin
        wr_d = wr_cur;
        if (wr_taken_i && wr_cur != CNT_MAX)
            wr_d = wr_cur + CNT_BITS'(1);
        else if (!wr_taken_i && wr_cur != '0)
            wr_d = wr_cur - CNT_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= CNT_INIT;
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= wr_d;
        end
    end
endmodule

// File: rtl/bp_gshare_btb.sv
// Branch predictor: direct-mapped BTB plus bimodal/gshare PHT, trained from the M stage.
// Lookup is combinational; updates commit on the next edge. There is no backpressure.
module bp_gshare_btb
    import bp_gshare_btb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int PHT_ENTRIES = 256,
    parameter int HIST_BITS   = 8,
    parameter int CNT_BITS    = 2,
    parameter int MODE        = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           pc,
    output logic                            pred_taken,
    output logic [DATA_WIDTH-1:0]           pred_target,
    output logic [$clog2(PHT_ENTRIES)-1:0]  pred_idx,
    input  logic                            upd_valid,
    input  logic [DATA_WIDTH-1:0]           upd_pc,
    input  logic                            upd_is_jump,
    input  logic                            upd_taken,
    input  logic [DATA_WIDTH-1:0]           upd_target,
    input  logic [$clog2(PHT_ENTRIES)-1:0]  upd_idx,
    input  logic                            upd_mispred,
    output logic [31:0]                     br_cnt,
    output logic [31:0]                     mis_cnt
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int PIDX  = $clog2(PHT_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;

    logic                   btb_vld_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  btb_tgt_q [BTB_ENTRIES];
    logic                   btb_typ_q [BTB_ENTRIES];

    logic [HIST_BITS-1:0]   ghr_q, ghr_d;
    logic [31:0]            br_cnt_q, br_cnt_d;
    logic [31:0]            mis_cnt_q, mis_cnt_d;

    logic [IDX-1:0]         lk_bi, up_bi;
    logic [TAG_W-1:0]       lk_tag, up_tag;
    logic [PIDX-1:0]        pc_pidx;
    logic [CNT_BITS-1:0]    pht_cnt;
    logic                   hit;
    logic                   btb_wr;
    logic                   unused_upd_pc_lsb;

    assign lk_bi   = pc[IDX+1:2];
    assign lk_tag  = pc[DATA_WIDTH-1:IDX+2];
    assign up_bi   = upd_pc[IDX+1:2];
    assign up_tag  = upd_pc[DATA_WIDTH-1:IDX+2];
    assign pc_pidx = pc[PIDX+1:2];
    assign unused_upd_pc_lsb = ^upd_pc[1:0];

    // With HIST_BITS < PIDX the zero-extended history leaves the upper index bits pure PC.
    assign pred_idx = (MODE == BP_MODE_GSHARE) ? (pc_pidx ^ PIDX'(ghr_q)) : pc_pidx;

    assign hit         = btb_vld_q[lk_bi] && (btb_tag_q[lk_bi] == lk_tag);
    assign pred_taken  = hit && (btb_typ_q[lk_bi] || pht_cnt[CNT_BITS-1]);
    assign pred_target = pred_taken ? btb_tgt_q[lk_bi] : pc + DATA_WIDTH'(4);

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;
    assign btb_wr  = upd_valid && upd_taken;

    bp_pht #(
        .ENTRIES  (PHT_ENTRIES),
        .CNT_BITS (CNT_BITS)
    ) u_pht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (pred_idx),
        .rd_cnt_o   (pht_cnt),
        .wr_en_i    (upd_valid && !upd_is_jump),
        .wr_idx_i   (upd_idx),
        .wr_taken_i (upd_taken)
    );

    always_comb begin
        ghr_d     = ghr_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (upd_valid) begin
            // History is committed from resolved branches only, never speculatively.
            if (!upd_is_jump)
                ghr_d = HIST_BITS'({ghr_q, upd_taken});
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + 32'd1;
            if (upd_mispred && mis_cnt_q != '1)
                mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q     <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++)
                btb_vld_q[i] <= 1'b0;
        end else begin
            ghr_q     <= ghr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (btb_wr)
                btb_vld_q[up_bi] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && btb_wr) begin
            btb_tag_q[up_bi] <= up_tag;
            btb_tgt_q[up_bi] <= upd_target;
            btb_typ_q[up_bi] <= upd_is_jump ? BP_TYPE_J : BP_TYPE_BR;
        end
    end
endmodule

// File: tb/tb_bp_gshare_btb.sv
// Directed bench: a bimodal instance for BTB/PHT/counter behaviour, a gshare instance with 2-bit history.
module tb_bp_gshare_btb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_pred_taken, a_upd_valid, a_upd_is_jump, a_upd_taken, a_upd_mispred;
    logic [31:0] a_pc, a_pred_target, a_upd_pc, a_upd_target, a_br_cnt, a_mis_cnt;
    logic [7:0]  a_pred_idx, a_upd_idx;

    logic        b_rst, b_pred_taken, b_upd_valid, b_upd_is_jump, b_upd_taken, b_upd_mispred;
    logic [31:0] b_pc, b_pred_target, b_upd_pc, b_upd_target, b_br_cnt, b_mis_cnt;
    logic [7:0]  b_pred_idx, b_upd_idx;

    bp_gshare_btb #(.MODE(0)) u_a (
        .clk(clk), .rst(a_rst), .pc(a_pc),
        .pred_taken(a_pred_taken), .pred_target(a_pred_target), .pred_idx(a_pred_idx),
        .upd_valid(a_upd_valid), .upd_pc(a_upd_pc), .upd_is_jump(a_upd_is_jump),
        .upd_taken(a_upd_taken), .upd_target(a_upd_target), .upd_idx(a_upd_idx),
        .upd_mispred(a_upd_mispred), .br_cnt(a_br_cnt), .mis_cnt(a_mis_cnt)
    );

    bp_gshare_btb #(.MODE(1), .HIST_BITS(2)) u_b (
        .clk(clk), .rst(b_rst), .pc(b_pc),
        .pred_taken(b_pred_taken), .pred_target(b_pred_target), .pred_idx(b_pred_idx),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_is_jump(b_upd_is_jump),
        .upd_taken(b_upd_taken), .upd_target(b_upd_target), .upd_idx(b_upd_idx),
        .upd_mispred(b_upd_mispred), .br_cnt(b_br_cnt), .mis_cnt(b_mis_cnt)
    );

    logic [31:0] sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic a_resolve(input logic [31:0] p, input logic j, input logic t,
                             input logic [31:0] tg, input logic m);
        a_upd_valid = 1'b1; a_upd_pc = p; a_upd_is_jump = j; a_upd_taken = t;
        a_upd_target = tg; a_upd_idx = p[9:2]; a_upd_mispred = m;
        tick();
        a_upd_valid = 1'b0;
    endtask

    task automatic b_resolve(input logic [31:0] p, input logic t, input logic [31:0] tg,
                             input logic [7:0] idx, input logic m);
        b_upd_valid = 1'b1; b_upd_pc = p; b_upd_is_jump = 1'b0; b_upd_taken = t;
        b_upd_target = tg; b_upd_idx = idx; b_upd_mispred = m;
        tick();
        b_upd_valid = 1'b0;
    endtask

    task automatic a_look(input string tag, input logic [31:0] p, input logic tk, input logic [31:0] tg);
        a_pc = p;
        #1;
        exp({31'd0, tk}); chk({tag, "_taken"}, {31'd0, a_pred_taken});
        exp(tg);          chk({tag, "_target"}, a_pred_target);
    endtask

    task automatic a_cnts(input string tag, input logic [31:0] br, input logic [31:0] mis);
        exp(br);  chk({tag, "_br_cnt"}, a_br_cnt);
        exp(mis); chk({tag, "_mis_cnt"}, a_mis_cnt);
    endtask

    initial begin
        logic [1:0] ghr_m;
        logic [7:0] idx01, idx10;
        int         mis_late;
        logic       t, p;

        a_rst = 1'b1; a_pc = 32'h40; a_upd_valid = 1'b0; a_upd_pc = '0; a_upd_is_jump = 1'b0;
        a_upd_taken = 1'b0; a_upd_target = '0; a_upd_idx = '0; a_upd_mispred = 1'b0;
        b_rst = 1'b1; b_pc = 32'h40; b_upd_valid = 1'b0; b_upd_pc = '0; b_upd_is_jump = 1'b0;
        b_upd_taken = 1'b0; b_upd_target = '0; b_upd_idx = '0; b_upd_mispred = 1'b0;
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state
        a_look("rst", 32'h40, 1'b0, 32'h44);
        a_cnts("rst", 0, 0);
        exp(32'h10); chk("rst_pred_idx", {24'd0, a_pred_idx});

        // Train taken: 01 -> 10 -> 11
        a_resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b1);
        a_look("tr1", 32'h40, 1'b1, 32'h80);
        a_resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        a_look("tr2", 32'h40, 1'b1, 32'h80);
        a_cnts("tr2", 2, 1);

        // Not-taken: 11 -> 10 still taken, -> 01 not taken
        a_resolve(32'h40, 1'b0, 1'b0, 32'h80, 1'b1);
        a_look("nt1", 32'h40, 1'b1, 32'h80);
        a_resolve(32'h40, 1'b0, 1'b0, 32'h80, 1'b1);
        a_look("nt2", 32'h40, 1'b0, 32'h44);
        a_cnts("nt2", 4, 3);

        // Jump installs and predicts immediately; BTB-index alias with another tag misses
        a_resolve(32'h100, 1'b1, 1'b1, 32'h200, 1'b1);
        a_look("jal", 32'h100, 1'b1, 32'h200);
        a_look("alias", 32'h200, 1'b0, 32'h204);

        // Branch sharing the jump's PHT slot: one taken step from weakly-not-taken predicts taken,
        // one not-taken step returns it to not-taken, so the jump left the counter alone.
        a_resolve(32'h500, 1'b0, 1'b1, 32'h600, 1'b1);
        a_look("misalign", 32'h503, 1'b1, 32'h600);
        a_look("replaced", 32'h100, 1'b0, 32'h104);
        a_resolve(32'h500, 1'b0, 1'b0, 32'h600, 1'b1);
        a_look("pht_j", 32'h500, 1'b0, 32'h504);
        a_cnts("pht_j", 7, 6);

        // Same-cycle lookup and overwrite shows the old target, new one after the edge
        a_resolve(32'h304, 1'b1, 1'b1, 32'h400, 1'b0);
        a_upd_valid = 1'b1; a_upd_pc = 32'h304; a_upd_is_jump = 1'b1; a_upd_taken = 1'b1;
        a_upd_target = 32'h480; a_upd_idx = 8'hC1; a_upd_mispred = 1'b1;
        a_look("rbw_old", 32'h304, 1'b1, 32'h400);
        tick();
        a_upd_valid = 1'b0;
        a_look("rbw_new", 32'h304, 1'b1, 32'h480);
        a_cnts("rbw", 9, 7);

        // Reset wins over a concurrent update
        a_rst = 1'b1;
        a_upd_valid = 1'b1; a_upd_pc = 32'h40; a_upd_is_jump = 1'b0; a_upd_taken = 1'b1;
        a_upd_target = 32'h99; a_upd_idx = 8'h10; a_upd_mispred = 1'b1;
        tick();
        a_rst = 1'b0; a_upd_valid = 1'b0;
        a_look("rstupd_j", 32'h304, 1'b0, 32'h308);
        a_look("rstupd_b", 32'h40, 1'b0, 32'h44);
        a_cnts("rstupd", 0, 0);
        a_resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b1);
        a_look("post_rst", 32'h40, 1'b1, 32'h80);

        // Performance counter saturation
        force u_a.br_cnt_q = 32'hFFFF_FFFF;
        a_resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        release u_a.br_cnt_q;
        a_cnts("sat1", 32'hFFFF_FFFF, 1);
        a_resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        a_cnts("sat2", 32'hFFFF_FFFF, 1);

        // Gshare: alternating T/N branch, 2-bit history
        ghr_m = 2'b00; mis_late = 0; idx01 = '0; idx10 = '0;
        b_pc = 32'h40;
        for (int i = 0; i < 20; i++) begin
            t = (i % 2 == 0);
            exp({24'd0, 8'h10 ^ {6'd0, ghr_m}});
            chk("b_pred_idx", {24'd0, b_pred_idx});
            if (ghr_m == 2'b01) idx01 = b_pred_idx;
            if (ghr_m == 2'b10) idx10 = b_pred_idx;
            p = b_pred_taken;
            if (i >= 4 && p != t) mis_late++;
            b_resolve(32'h40, t, 32'h80, b_pred_idx, p != t);
            ghr_m = {ghr_m[0], t};
        end
        exp(0);  chk("b_late_mispred", mis_late);
        exp(1);  chk("b_idx_differs", {31'd0, idx01 != idx10});
        exp(20); chk("b_br_cnt", b_br_cnt);
        exp(2);  chk("b_mis_cnt", b_mis_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
